// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the front end and the control unit.
// Contents:
//   - major opcode constants (bits [6:0] of an instruction word)
//   - canonical NOP word (addi x0, x0, 0)
//   - fetch_unit state encoding, also exported on its debug state port
package rv_pkg;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_S    = 7'b0100011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_L    = 7'b0000011;
  localparam logic [6:0] OPC_B    = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,  // first cycle out of reset, no request
    ST_FETCH = 2'd1,  // normal operation
    ST_FLUSH = 2'd2   // dropping responses that predate a redirect
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched instructions, each entry {pc, inst}.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   push_i, push_pc_i,
//   push_inst_i           write one entry at the tail
//   pop_i                 drop the head entry (only when count_o != 0)
//   flush_i               empty the buffer; wins over push_i and pop_i
//   head_pc_o,
//   head_inst_o           head entry (meaningless when count_o == 0)
//   count_o               number of valid entries, 0..DEPTH
// The caller guarantees no push when full and no pop when empty.
module fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [31:0]              push_pc_i,
  input  logic [31:0]              push_inst_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [31:0]              head_pc_o,
  output logic [31:0]              head_inst_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  // DEPTH is a power of two, so pointer increments wrap for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset: count_q gates every read of it.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= {push_pc_i, push_inst_i};
  end

  assign head_pc_o   = mem_q[rd_ptr_q][63:32];
  assign head_inst_o = mem_q[rd_ptr_q][31:0];
  assign count_o     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction
// memory and presents buffered instructions to decode.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   imem_req, imem_addr       request and word-aligned byte address
//   imem_gnt                  request accepted when imem_req && imem_gnt
//   imem_rvalid, imem_rdata   in-order responses, >= 1 cycle after grant
//   redirect, redirect_pc     one-cycle restart pulse and target
//   inst_valid, inst_ready    decode handshake
//   inst, inst_pc, opcode     head instruction, its PC and inst[6:0]
//   dbg_state_o               current FSM state
//
// Handshakes: a transfer happens on a rising edge where the producer's
// valid (imem_req / inst_valid) and the consumer's accept (imem_gnt /
// inst_ready) are both high; imem_rvalid needs no accept. Producers keep
// valid and payload stable until the transfer, except that a redirect
// withdraws a pending memory request and voids any decode transfer in
// the same cycle.
//
// Credit scheme: a request is issued only while outstanding requests plus
// buffered entries stay below DEPTH, so every response has a slot.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         inst_valid,
  input  logic         inst_ready,
  output logic [31:0]  inst,
  output logic [31:0]  inst_pc,
  output logic [6:0]   opcode,
  output fetch_state_e dbg_state_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;   // PC of the next expected response
  logic [31:0]   last_pc_q, last_pc_d;   // PC of the last popped entry
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] fifo_count;
  logic [31:0]   head_pc, head_inst, redirect_tgt;
  logic          gnt_fire, redirect_act, out_fire, push;

  assign redirect_tgt = redirect_pc & ~32'd3;
  // A redirect during BOOT is ignored.
  assign redirect_act = redirect && (state_q != ST_BOOT);

  assign imem_req  = (state_q == ST_FETCH) && ((outst_q + fifo_count) < CW'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign gnt_fire  = imem_req && imem_gnt;

  // Responses arriving in the redirect cycle belong to the old stream.
  assign push     = imem_rvalid && (state_q == ST_FETCH) && !redirect_act;
  assign out_fire = inst_valid && inst_ready && !redirect_act;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    last_pc_d  = last_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;

    case (state_q)
      ST_BOOT: state_d = ST_FETCH;

      ST_FETCH: begin
        if (redirect_act) begin
          fetch_pc_d = redirect_tgt;
          resp_pc_d  = redirect_tgt;
          // Everything granted so far (including this cycle) and not yet
          // answered is stale.
          discard_d  = outst_q + CW'(gnt_fire) - CW'(imem_rvalid);
          outst_d    = '0;
          state_d    = (discard_d != '0) ? ST_FLUSH : ST_FETCH;
        end else begin
          if (gnt_fire) fetch_pc_d = fetch_pc_q + 32'd4;
          if (push)     resp_pc_d  = resp_pc_q + 32'd4;
          outst_d = outst_q + CW'(gnt_fire) - CW'(imem_rvalid);
        end
      end

      ST_FLUSH: begin
        // The buffer is already empty here; only the target moves.
        if (redirect_act) begin
          fetch_pc_d = redirect_tgt;
          resp_pc_d  = redirect_tgt;
        end
        if (imem_rvalid) discard_d = discard_q - CW'(1);
        if (discard_d == '0) state_d = ST_FETCH;
      end

      default: state_d = ST_BOOT;
    endcase

    if (out_fire) last_pc_d = head_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      last_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      last_pc_q  <= last_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_pc_i   (resp_pc_q),
    .push_inst_i (imem_rdata),
    .pop_i       (out_fire),
    .flush_i     (redirect_act),
    .head_pc_o   (head_pc),
    .head_inst_o (head_inst),
    .count_o     (fifo_count)
  );

  assign inst_valid  = (fifo_count != '0);
  assign inst        = inst_valid ? head_inst : NOP_WORD;
  assign inst_pc     = inst_valid ? head_pc : last_pc_q;
  assign opcode      = inst[6:0];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import rv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         imem_req, imem_gnt, imem_rvalid;
  logic [31:0]  imem_addr, imem_rdata;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         inst_valid, inst_ready;
  logic [31:0]  inst, inst_pc;
  logic [6:0]   opcode;
  fetch_state_e dbg_state;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .opcode      (opcode),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic [31:0] addr;   // address the DUT put on the bus
    logic [31:0] mpc;    // address the model expected
    int          due;    // cycle in which the response is returned
    int          epoch;  // redirect generation it was issued in
  } pend_t;

  pend_t       pend_q[$];       // memory: granted, not yet answered
  logic [63:0] exp_q[$];        // expected buffer contents {pc, inst}
  int          epoch, cyc, last_due;
  logic [31:0] exp_fetch_pc, last_pop_pc;
  bit          boot, wrap_seen;

  // Stimulus knobs
  int          gnt_pct, ready_pct, redir_pct, lat_min, lat_max;
  bit          force_gnt0, do_redirect;
  logic [31:0] forced_tgt;

  int n_cmp, n_err;

  task automatic tb_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Memory contents: a scrambled word whose opcode depends on the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    case (a[4:2])
      3'd0: w[6:0] = 7'b0110011;
      3'd1: w[6:0] = 7'b0100011;
      3'd2: w[6:0] = 7'b0010011;
      3'd3: w[6:0] = 7'b0000011;
      3'd4: w[6:0] = 7'b1100011;
      3'd5: w[6:0] = 7'b1101111;
      3'd6: w[6:0] = 7'b1100111;
      default: w[6:0] = 7'b0010011;
    endcase
    return w;
  endfunction

  // One cycle: called #1 after a rising edge. Checks the outputs against
  // the model, drives inputs for the next edge, advances the model.
  task automatic step();
    int          stale_n, lat;
    bit          req_exp, g, rv, rdy, rd, has_head;
    logic [31:0] tgt;
    logic [63:0] head;
    pend_t       p;
    fetch_state_e st_exp;

    stale_n = 0;
    foreach (pend_q[k]) if (pend_q[k].epoch != epoch) stale_n++;
    req_exp = !boot && (stale_n == 0) && (pend_q.size() + exp_q.size() < DEPTH);
    st_exp  = boot ? ST_BOOT : (stale_n > 0 ? ST_FLUSH : ST_FETCH);

    tb_check("imem_req", 64'(imem_req), 64'(req_exp));
    tb_check("imem_addr", 64'(imem_addr), 64'(exp_fetch_pc));
    tb_check("state", 64'(dbg_state), 64'(st_exp));
    has_head = (exp_q.size() != 0);
    tb_check("inst_valid", 64'(inst_valid), 64'(has_head));
    if (has_head) begin
      head = exp_q[0];
      tb_check("inst_pc", 64'(inst_pc), 64'(head[63:32]));
      tb_check("inst", 64'(inst), 64'(head[31:0]));
      tb_check("opcode", 64'(opcode), 64'(head[6:0]));
    end else begin
      tb_check("idle_inst", 64'(inst), 64'h13);
      tb_check("idle_pc", 64'(inst_pc), 64'(last_pop_pc));
    end

    // Drive inputs for the coming edge.
    g   = force_gnt0 ? 1'b0 : ($urandom_range(99) < gnt_pct);
    rv  = (pend_q.size() != 0) && (pend_q[0].due <= cyc);
    rdy = ($urandom_range(99) < ready_pct);
    rd  = do_redirect || (!boot && redir_pct > 0 && $urandom_range(99) < redir_pct);
    tgt = do_redirect ? forced_tgt : $urandom();
    do_redirect = 1'b0;

    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(pend_q[0].addr) : $urandom();
    inst_ready  = rdy;
    redirect    = rd;
    redirect_pc = rd ? tgt : $urandom();

    // Model update for what happens at the edge.
    if (has_head && rdy && !rd) begin
      head = exp_q.pop_front();
      last_pop_pc = head[63:32];
    end
    if (rv) begin
      p = pend_q.pop_front();
      if (p.epoch == epoch && !rd) exp_q.push_back({p.mpc, mem_word(p.mpc)});
    end
    if (imem_req && g) begin
      if (imem_addr == 32'h0) wrap_seen = 1'b1;
      lat = $urandom_range(lat_max, lat_min);
      p.addr  = imem_addr;
      p.mpc   = exp_fetch_pc;
      p.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      p.epoch = epoch;
      last_due = p.due;
      pend_q.push_back(p);
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    if (rd) begin
      exp_q.delete();
      exp_fetch_pc = tgt & ~32'd3;
      epoch++;
    end
    boot = 1'b0;

    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_knobs(input int gp, input int rp, input int dp, input int lmin, input int lmax);
    gnt_pct = gp; ready_pct = rp; redir_pct = dp; lat_min = lmin; lat_max = lmax;
  endtask

  // Leaves the bench #1 after a rising edge with rst just released (BOOT).
  task automatic do_reset();
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tb_check("rst_req", 64'(imem_req), 64'h0);
    tb_check("rst_addr", 64'(imem_addr), 64'(RST_PC));
    tb_check("rst_valid", 64'(inst_valid), 64'h0);
    tb_check("rst_inst", 64'(inst), 64'h13);
    tb_check("rst_opcode", 64'(opcode), 64'h13);
    tb_check("rst_pc", 64'(inst_pc), 64'(RST_PC));
    pend_q.delete();
    exp_q.delete();
    epoch = 0; cyc = 0; last_due = 0;
    exp_fetch_pc = RST_PC; last_pop_pc = RST_PC;
    boot = 1'b1; do_redirect = 1'b0; force_gnt0 = 1'b0;
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_cmp = 0; n_err = 0;
    forced_tgt = '0; wrap_seen = 1'b0;
    set_knobs(100, 100, 0, 1, 1);

    // Streaming: one instruction per cycle from cycle 3 on.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i >= 3) tb_check("throughput_valid", 64'(inst_valid), 64'h1);
      step();
    end

    // Grant withheld for three cycles: request and address hold.
    do_reset();
    force_gnt0 = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      tb_check("gnt_wait_req", 64'(imem_req), 64'h1);
      tb_check("gnt_wait_addr", 64'(imem_addr), 64'h100);
      step();
    end
    force_gnt0 = 1'b0;
    tb_check("gnt_wait_addr_end", 64'(imem_addr), 64'h100);
    repeat (8) step();

    // Decode stalled: credit runs out, then the buffer drains in order.
    ready_pct = 0;
    repeat (12) step();
    tb_check("stall_req_off", 64'(imem_req), 64'h0);
    tb_check("stall_full", 64'(inst_valid), 64'h1);
    ready_pct = 100;
    repeat (15) step();

    // Redirect with requests outstanding (two-cycle memory latency).
    set_knobs(100, 100, 0, 2, 2);
    repeat (8) step();
    do_redirect = 1'b1; forced_tgt = 32'h0000_0203;
    step();
    tb_check("redir_flush_state", 64'(dbg_state), 64'(ST_FLUSH));
    tb_check("redir_no_req", 64'(imem_req), 64'h0);
    tb_check("redir_no_valid", 64'(inst_valid), 64'h0);
    repeat (12) step();

    // Redirect coinciding with grant, response and decode handshake.
    set_knobs(100, 100, 0, 1, 1);
    repeat (6) step();
    tb_check("coinc_setup_req", 64'(imem_req), 64'h1);
    tb_check("coinc_setup_valid", 64'(inst_valid), 64'h1);
    do_redirect = 1'b1; forced_tgt = 32'h0000_0200;
    step();
    tb_check("coinc_flush_state", 64'(dbg_state), 64'(ST_FLUSH));
    repeat (10) step();

    // Sequential fetch across the top of the address space.
    wrap_seen = 1'b0;
    do_redirect = 1'b1; forced_tgt = 32'hFFFF_FFF6;
    repeat (12) step();
    tb_check("pc_wrap_seen", 64'(wrap_seen), 64'h1);

    // Random traffic with random redirects.
    set_knobs(70, 70, 3, 1, 4);
    repeat (3000) step();

    // Reset mid-stream with a full buffer and an idle memory.
    set_knobs(100, 0, 0, 1, 1);
    repeat (8) step();
    gnt_pct = 0;
    for (int k = 0; k < 40 && pend_q.size() != 0; k++) step();
    tb_check("drain_before_rst", 64'(pend_q.size()), 64'h0);
    rst = 1'b1;
    #1;
    tb_check("midrst_req", 64'(imem_req), 64'h0);
    tb_check("midrst_addr", 64'(imem_addr), 64'(RST_PC));
    tb_check("midrst_valid", 64'(inst_valid), 64'h0);
    tb_check("midrst_inst", 64'(inst), 64'h13);
    tb_check("midrst_pc", 64'(inst_pc), 64'(RST_PC));
    tb_check("midrst_state", 64'(dbg_state), 64'(ST_BOOT));
    do_reset();
    set_knobs(80, 60, 2, 1, 3);
    repeat (300) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
